// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle accumulator control unit.
// State list includes HALT, which is only reachable when CU_HALT_EN is defined.
package cu_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        WB_ALU   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BR_CMP   = 4'd10,
        BR_TAKE  = 4'd11,
        JUMP     = 4'd12,
        HALT     = 4'd13
    } state_t;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQZ = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/cu_output_decoder.sv
// Moore output map: datapath strobes and selects from the current state,
// with Func[0] and toaccIn only consulted in EXEC_R and the write-back states.
module cu_output_decoder
    import cu_pkg::*;
(
    input  state_t state,
    input  logic   func0,
    input  logic   toacc_in,
    output logic   PCWrite,
    output logic   IorM,
    output logic   MemWrite,
    output logic   IRWrite,
    output logic   toacc,
    output logic   ItypeSel,
    output logic   Asel,
    output logic   Bsel,
    output logic   Awrite,
    output logic   Bwrite,
    output logic   RegWrite,
    output logic   IsZeroWrite,
    output logic   ALUCtrl,
    output logic   Jcontrol,
    output logic   ALUWrite
);

    // Per-state strobe decode; IDLE, HALT and illegal encodings leave everything low.
    always_comb begin
        PCWrite     = 1'b0;
        IorM        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        toacc       = 1'b0;
        ItypeSel    = 1'b0;
        Asel        = 1'b0;
        Bsel        = 1'b0;
        Awrite      = 1'b0;
        Bwrite      = 1'b0;
        RegWrite    = 1'b0;
        IsZeroWrite = 1'b0;
        ALUCtrl     = ALU_ADD;
        Jcontrol    = 1'b0;
        ALUWrite    = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                Asel    = 1'b1;
                Bsel    = 1'b1;
            end
            DECODE: begin
                Awrite = 1'b1;
                Bwrite = 1'b1;
            end
            EXEC_R: begin
                ALUWrite = 1'b1;
                ALUCtrl  = func0 ? ALU_SUB : ALU_ADD;
            end
            EXEC_I, MEM_ADDR: begin
                ALUWrite = 1'b1;
                ItypeSel = 1'b1;
                Bsel     = 1'b1;
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                toacc    = toacc_in;
            end
            MEM_RD: begin
                IorM = 1'b1;
            end
            WB_MEM: begin
                RegWrite = 1'b1;
                IorM     = 1'b1;
                toacc    = toacc_in;
            end
            MEM_WR: begin
                IorM     = 1'b1;
                MemWrite = 1'b1;
            end
            BR_CMP: begin
                IsZeroWrite = 1'b1;
                ALUCtrl     = ALU_SUB;
            end
            BR_TAKE: begin
                Jcontrol = 1'b1;
            end
            JUMP: begin
                Jcontrol = 1'b1;
                PCWrite  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the 16-bit accumulator datapath.
// Optional CU_HALT_EN: opcode 0xF enters HALT until Reset; otherwise 0xF is a NOP.
module control_unit
    import cu_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic [3:0] Func,
    input  logic       toaccIn,
    output logic       PCWrite,
    output logic       IorM,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       toacc,
    output logic       ItypeSel,
    output logic       Asel,
    output logic       Bsel,
    output logic       Awrite,
    output logic       Bwrite,
    output logic       RegWrite,
    output logic       IsZeroWrite,
    output logic       ALUCtrl,
    output logic       Jcontrol,
    output logic       ALUWrite
);

    state_t state_r;
    state_t next_state_s;
    logic   func_unused_s;

    assign func_unused_s = ^Func[3:1];

    // State register with synchronous reset into IDLE.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; anything not recognised falls back to IDLE.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE:   next_state_s = FETCH;
            FETCH:  next_state_s = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_R:    next_state_s = EXEC_R;
                    OP_ADDI: next_state_s = EXEC_I;
                    OP_LW,
                    OP_SW:   next_state_s = MEM_ADDR;
                    OP_BEQZ: next_state_s = BR_CMP;
                    OP_J:    next_state_s = JUMP;
`ifdef CU_HALT_EN
                    OP_HALT: next_state_s = HALT;
`endif
                    default: next_state_s = FETCH;
                endcase
            end
            EXEC_R, EXEC_I: next_state_s = WB_ALU;
            MEM_ADDR: begin
                if (Opcode == OP_LW) begin
                    next_state_s = MEM_RD;
                end else begin
                    next_state_s = MEM_WR;
                end
            end
            MEM_RD:  next_state_s = WB_MEM;
            BR_CMP:  next_state_s = BR_TAKE;
            WB_ALU, WB_MEM, MEM_WR, BR_TAKE, JUMP: next_state_s = FETCH;
`ifdef CU_HALT_EN
            HALT:    next_state_s = HALT;
`endif
            default: next_state_s = IDLE;
        endcase
    end

    cu_output_decoder u_output_decoder (
        .state       (state_r),
        .func0       (Func[0]),
        .toacc_in    (toaccIn),
        .PCWrite     (PCWrite),
        .IorM        (IorM),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .toacc       (toacc),
        .ItypeSel    (ItypeSel),
        .Asel        (Asel),
        .Bsel        (Bsel),
        .Awrite      (Awrite),
        .Bwrite      (Bwrite),
        .RegWrite    (RegWrite),
        .IsZeroWrite (IsZeroWrite),
        .ALUCtrl     (ALUCtrl),
        .Jcontrol    (Jcontrol),
        .ALUWrite    (ALUWrite)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into its
// expected per-cycle strobe list by a behavioural model and compared cycle by cycle.
module tb_control_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] Opcode;
    logic [3:0] Func;
    logic       toaccIn;
    logic PCWrite, IorM, MemWrite, IRWrite, toacc, ItypeSel, Asel, Bsel;
    logic Awrite, Bwrite, RegWrite, IsZeroWrite, ALUCtrl, Jcontrol, ALUWrite;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [14:0] M_PCW   = 15'h4000;
    localparam logic [14:0] M_IORM  = 15'h2000;
    localparam logic [14:0] M_MEMW  = 15'h1000;
    localparam logic [14:0] M_IRW   = 15'h0800;
    localparam logic [14:0] M_TOACC = 15'h0400;
    localparam logic [14:0] M_ITYPE = 15'h0200;
    localparam logic [14:0] M_ASEL  = 15'h0100;
    localparam logic [14:0] M_BSEL  = 15'h0080;
    localparam logic [14:0] M_AW    = 15'h0040;
    localparam logic [14:0] M_BW    = 15'h0020;
    localparam logic [14:0] M_REGW  = 15'h0010;
    localparam logic [14:0] M_ISZ   = 15'h0008;
    localparam logic [14:0] M_ALUC  = 15'h0004;
    localparam logic [14:0] M_JC    = 15'h0002;
    localparam logic [14:0] M_ALUW  = 15'h0001;
    localparam logic [14:0] V_FETCH = M_IRW | M_PCW | M_ASEL | M_BSEL;
    localparam logic [14:0] V_ZERO  = 15'h0000;

    logic [14:0] obs_s;
    logic [14:0] exp_q[$];

    assign obs_s = {PCWrite, IorM, MemWrite, IRWrite, toacc, ItypeSel, Asel, Bsel,
                    Awrite, Bwrite, RegWrite, IsZeroWrite, ALUCtrl, Jcontrol, ALUWrite};

    control_unit dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Func(Func), .toaccIn(toaccIn),
        .PCWrite(PCWrite), .IorM(IorM), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .toacc(toacc), .ItypeSel(ItypeSel), .Asel(Asel), .Bsel(Bsel),
        .Awrite(Awrite), .Bwrite(Bwrite), .RegWrite(RegWrite),
        .IsZeroWrite(IsZeroWrite), .ALUCtrl(ALUCtrl), .Jcontrol(Jcontrol),
        .ALUWrite(ALUWrite)
    );

    always #5 CLK = ~CLK;

    // Expected strobe vectors for every cycle after FETCH, ending with the next FETCH.
    function automatic void build_trace(input logic [3:0] op, input logic f0, input logic ta);
        logic [14:0] wb;
        wb = M_REGW | (ta ? M_TOACC : V_ZERO);
        exp_q.delete();
        exp_q.push_back(M_AW | M_BW);
        case (op)
            4'd0: begin
                exp_q.push_back(M_ALUW | (f0 ? M_ALUC : V_ZERO));
                exp_q.push_back(wb);
            end
            4'd1: begin
                exp_q.push_back(M_ALUW | M_ITYPE | M_BSEL);
                exp_q.push_back(wb);
            end
            4'd2: begin
                exp_q.push_back(M_ALUW | M_ITYPE | M_BSEL);
                exp_q.push_back(M_IORM);
                exp_q.push_back(wb | M_IORM);
            end
            4'd3: begin
                exp_q.push_back(M_ALUW | M_ITYPE | M_BSEL);
                exp_q.push_back(M_IORM | M_MEMW);
            end
            4'd4: begin
                exp_q.push_back(M_ISZ | M_ALUC);
                exp_q.push_back(M_JC);
            end
            4'd5: exp_q.push_back(M_JC | M_PCW);
`ifdef CU_HALT_EN
            4'd15: begin
                for (int k = 0; k < 6; k++) exp_q.push_back(V_ZERO);
                return;
            end
`endif
            default: begin
            end
        endcase
        exp_q.push_back(V_FETCH);
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Opcode = 4'd0; Func = 4'd0; toaccIn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (obs_s !== V_ZERO) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", obs_s, V_ZERO);
        end
        Reset = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (obs_s !== V_FETCH) begin
            n_fail++; $display("FAIL reset_fetch: got %h expected %h", obs_s, V_FETCH);
        end
    endtask

    task automatic test_lw();
        Opcode = 4'd2; Func = 4'd0; toaccIn = 1'b1;
        build_trace(Opcode, Func[0], toaccIn);
        foreach (exp_q[i]) begin
            @(posedge CLK); #1;
            n_checks++;
            if (obs_s !== exp_q[i]) begin
                n_fail++; $display("FAIL lw step %0d: got %h expected %h", i, obs_s, exp_q[i]);
            end
        end
    endtask

    task automatic test_r_type();
        Opcode = 4'd0; Func = 4'd1; toaccIn = 1'b0;
        build_trace(Opcode, Func[0], toaccIn);
        foreach (exp_q[i]) begin
            @(posedge CLK); #1;
            n_checks++;
            if (obs_s !== exp_q[i]) begin
                n_fail++; $display("FAIL r_type step %0d: got %h expected %h", i, obs_s, exp_q[i]);
            end
        end
    endtask

    task automatic test_sw_j();
        for (int n = 0; n < 2; n++) begin
            Opcode = (n == 0) ? 4'd3 : 4'd5; Func = 4'd0; toaccIn = 1'b1;
            build_trace(Opcode, Func[0], toaccIn);
            foreach (exp_q[i]) begin
                @(posedge CLK); #1;
                n_checks++;
                if (obs_s !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL sw_j op %0d step %0d: got %h expected %h", Opcode, i, obs_s, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_beqz();
        Opcode = 4'd4; Func = 4'd0; toaccIn = 1'b0;
        build_trace(Opcode, Func[0], toaccIn);
        foreach (exp_q[i]) begin
            @(posedge CLK); #1;
            n_checks++;
            if (obs_s !== exp_q[i]) begin
                n_fail++; $display("FAIL beqz step %0d: got %h expected %h", i, obs_s, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            Opcode = 4'($urandom_range(0, 15));
`ifdef CU_HALT_EN
            if (Opcode == 4'd15) Opcode = 4'd14;
`endif
            Func = 4'($urandom_range(0, 15));
            toaccIn = 1'($urandom_range(0, 1));
            build_trace(Opcode, Func[0], toaccIn);
            foreach (exp_q[i]) begin
                @(posedge CLK); #1;
                n_checks++;
                if (obs_s !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random op %0d f %0d ta %0d step %0d: got %h expected %h",
                             Opcode, Func, toaccIn, i, obs_s, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        Opcode = 4'd3; Func = 4'd0; toaccIn = 1'b0;
        build_trace(Opcode, Func[0], toaccIn);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (obs_s !== exp_q[i]) begin
                n_fail++; $display("FAIL reset_mid step %0d: got %h expected %h", i, obs_s, exp_q[i]);
            end
        end
        Reset = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (obs_s !== V_ZERO) begin
            n_fail++; $display("FAIL reset_mid_idle: got %h expected %h", obs_s, V_ZERO);
        end
        Reset = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (obs_s !== V_FETCH) begin
            n_fail++; $display("FAIL reset_mid_fetch: got %h expected %h", obs_s, V_FETCH);
        end
    endtask

    task automatic test_op15();
        Opcode = 4'd15; Func = 4'd1; toaccIn = 1'b1;
        build_trace(Opcode, Func[0], toaccIn);
        foreach (exp_q[i]) begin
            @(posedge CLK); #1;
            n_checks++;
            if (obs_s !== exp_q[i]) begin
                n_fail++; $display("FAIL op15 step %0d: got %h expected %h", i, obs_s, exp_q[i]);
            end
        end
`ifdef CU_HALT_EN
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (obs_s !== V_FETCH) begin
            n_fail++; $display("FAIL halt_release: got %h expected %h", obs_s, V_FETCH);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_type();
        test_sw_j();
        test_beqz();
        test_random();
        test_reset_mid();
        test_op15();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
